fir_tdm_controller: RTL and testbench

FIR_TDM_CONTROLLER -- requirements
Module: fir_tdm_controller

---
 rtl/fir_tdm_controller.sv | 126 ++++++++++++
 tb/tb_fir_tdm_controller.sv | 252 +++++++++++++++++++++++++
 2 files changed

// File: rtl/fir_tdm_controller.sv
// Time-multiplexed FIR filter controller.
// One shared multiplier walks all taps per accepted sample.
module fir_tdm_controller #(
  parameter int TAPS = 123,
  parameter int DW   = 17,
  parameter int AW   = 7,
  parameter int ACCW = 48
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   in_valid,
  input  logic signed [DW-1:0]   in_data,
  output logic                   in_ready,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic signed [ACCW-1:0] y_out,
  input  logic                   coef_we,
  input  logic [AW-1:0]          coef_addr,
  input  logic signed [DW-1:0]   coef_data,
  output logic                   coef_err,
  input  logic                   hist_clr,
  output logic                   busy
);

  typedef enum logic [1:0] {
    IDLE,
    MAC,
    DONE
  } state_t;

  state_t state_q, state_d;

  logic signed [DW-1:0]   h_q [TAPS];
  logic signed [DW-1:0]   x_q [TAPS];
  logic [AW-1:0]          wr_ptr_q;
  logic [AW-1:0]          rd_ptr_q;
  logic [AW-1:0]          k_q;
  logic signed [ACCW-1:0] acc_q;
  logic signed [ACCW-1:0] y_q;
  logic                   out_valid_q;
  logic                   coef_err_q;

  logic                   accept;
  logic                   last;
  logic                   addr_ok;
  logic                   coef_ok;
  logic                   clr_ok;
  logic signed [2*DW-1:0] prod;
  logic signed [ACCW-1:0] prod_ext;
  logic signed [ACCW-1:0] sum;

  assign in_ready  = (state_q == IDLE) & ~coef_we & ~hist_clr;
  assign accept    = in_valid & in_ready;
  assign last      = (k_q == AW'(TAPS - 1));
  assign addr_ok   = ({1'b0, coef_addr} < (AW + 1)'(TAPS));
  assign coef_ok   = coef_we & (state_q == IDLE) & addr_ok;
  assign clr_ok    = hist_clr & (state_q == IDLE);
  assign prod      = h_q[k_q] * x_q[rd_ptr_q];
  assign prod_ext  = {{(ACCW - 2 * DW){prod[2*DW-1]}}, prod};
  assign sum       = acc_q + prod_ext;
  assign busy      = (state_q != IDLE);
  assign out_valid = out_valid_q;
  assign y_out     = y_q;
  assign coef_err  = coef_err_q;

  // State register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  // Next-state: accept -> MAC for TAPS cycles -> DONE until taken.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (accept)    state_d = MAC;
      MAC:     if (last)      state_d = DONE;
      DONE:    if (out_ready) state_d = IDLE;
      default:                state_d = IDLE;
    endcase
  end

  // Coefficient/sample storage, MAC datapath and output register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < TAPS; i++) begin
        h_q[i] <= '0;
        x_q[i] <= '0;
      end
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      k_q         <= '0;
      acc_q       <= '0;
      y_q         <= '0;
      out_valid_q <= 1'b0;
      coef_err_q  <= 1'b0;
    end else begin
      coef_err_q <= coef_we & ~coef_ok;
      if (coef_ok) h_q[coef_addr] <= coef_data;
      if (clr_ok) begin
        for (int i = 0; i < TAPS; i++) x_q[i] <= '0;
        wr_ptr_q <= '0;
      end
      if (accept) begin
        x_q[wr_ptr_q] <= in_data;
        acc_q         <= '0;
        k_q           <= '0;
        rd_ptr_q      <= wr_ptr_q;
      end
      if (state_q == MAC) begin
        acc_q    <= sum;
        k_q      <= k_q + 1'b1;
        rd_ptr_q <= (rd_ptr_q == '0) ? AW'(TAPS - 1)
                                     : rd_ptr_q - 1'b1;
        if (last) begin
          y_q         <= sum;
          out_valid_q <= 1'b1;
          wr_ptr_q    <= (wr_ptr_q == AW'(TAPS - 1)) ? '0
                                                     : wr_ptr_q + 1'b1;
        end
      end
      if (state_q == DONE && out_ready) out_valid_q <= 1'b0;
    end
  end

endmodule

// File: tb/tb_fir_tdm_controller.sv
// Self-checking bench for fir_tdm_controller.
// Reference model plus scoreboard queue of expected outputs.
module tb_fir_tdm_controller;

  localparam int TAPS = 123;
  localparam int DW   = 17;
  localparam int AW   = 7;
  localparam int ACCW = 48;

  logic                   clk = 1'b0;
  logic                   reset = 1'b1;
  logic                   in_valid = 1'b0;
  logic signed [DW-1:0]   in_data = '0;
  logic                   in_ready;
  logic                   out_valid;
  logic                   out_ready = 1'b1;
  logic signed [ACCW-1:0] y_out;
  logic                   coef_we = 1'b0;
  logic [AW-1:0]          coef_addr = '0;
  logic signed [DW-1:0]   coef_data = '0;
  logic                   coef_err;
  logic                   hist_clr = 1'b0;
  logic                   busy;

  fir_tdm_controller #(
    .TAPS(TAPS), .DW(DW), .AW(AW), .ACCW(ACCW)
  ) dut (
    .clk(clk), .reset(reset),
    .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
    .out_valid(out_valid), .out_ready(out_ready), .y_out(y_out),
    .coef_we(coef_we), .coef_addr(coef_addr), .coef_data(coef_data),
    .coef_err(coef_err), .hist_clr(hist_clr), .busy(busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic signed [DW-1:0] x;
    longint               y;
  } vec_t;

  vec_t   tbl [TAPS];
  longint hm [TAPS];
  longint xm [TAPS];
  int     wp;
  longint sb [$];
  int     checks;
  int     failures;

  task automatic chk(input string name, input longint act,
                     input longint exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d", name, act, exp);
    end
  endtask

  function automatic longint model_push(input longint s);
    longint y;
    xm[wp] = s;
    y = 0;
    for (int k = 0; k < TAPS; k++)
      y += hm[k] * xm[(wp - k + TAPS) % TAPS];
    wp = (wp + 1) % TAPS;
    return y;
  endfunction

  task automatic idle_wait();
    int n;
    n = 0;
    while (busy && n < 300) begin
      @(negedge clk);
      n++;
    end
    if (busy) chk("idle_timeout", 1, 0);
  endtask

  task automatic wcoef(input int a, input longint d);
    idle_wait();
    coef_we   = 1'b1;
    coef_addr = AW'(a);
    coef_data = DW'(d);
    @(posedge clk);
    #1 coef_we = 1'b0;
    if (a < TAPS) hm[a] = d;
  endtask

  task automatic hclr();
    idle_wait();
    hist_clr = 1'b1;
    @(posedge clk);
    #1 hist_clr = 1'b0;
    for (int i = 0; i < TAPS; i++) xm[i] = 0;
    wp = 0;
  endtask

  task automatic send(input logic signed [DW-1:0] s,
                      input bit use_exp, input longint exp,
                      input bit inject);
    int     n;
    longint e;
    n = 0;
    while (!in_ready && n < 300) begin
      @(negedge clk);
      n++;
    end
    if (!in_ready) begin
      chk("in_ready_timeout", 0, 1);
      return;
    end
    e = model_push(longint'(s));
    sb.push_back(use_exp ? exp : e);
    in_valid = 1'b1;
    in_data  = s;
    @(posedge clk);
    #1 in_valid = 1'b0;
    n = 0;
    while (!out_valid && n < 300) begin
      if (inject && n == 5) begin
        coef_we   = 1'b1;
        coef_addr = AW'(5);
        coef_data = DW'(7);
      end
      @(posedge clk);
      #1 n++;
      coef_we = 1'b0;
      if (inject && n == 6) chk("coef_err_mac_pulse", coef_err, 1);
      if (inject && n == 7) chk("coef_err_mac_clear", coef_err, 0);
    end
    chk("latency", n, TAPS);
    e = sb.pop_front();
    if (out_valid) chk("y_out", longint'(y_out), e);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    longint held;
    int     seen;
    checks   = 0;
    failures = 0;
    wp       = 0;
    for (int i = 0; i < TAPS; i++) begin
      hm[i] = 0;
      xm[i] = 0;
      tbl[i].x = (i == 0) ? DW'(1) : DW'(0);
      tbl[i].y = i + 1;
    end

    repeat (3) @(posedge clk);
    #1;
    chk("rst_out_valid", out_valid, 0);
    chk("rst_y_out", longint'(y_out), 0);
    chk("rst_busy", busy, 0);
    chk("rst_coef_err", coef_err, 0);
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    chk("rst_in_ready", in_ready, 1);

    for (int k = 0; k < TAPS; k++) wcoef(k, k + 1);
    chk("good_write_no_err", coef_err, 0);

    for (int i = 0; i < TAPS; i++)
      send(tbl[i].x, 1'b1, tbl[i].y, i == 3);

    wcoef(TAPS, 99);
    chk("coef_err_addr_pulse", coef_err, 1);
    @(posedge clk);
    #1 chk("coef_err_addr_clear", coef_err, 0);

    out_ready = 1'b0;
    send(DW'(5), 1'b0, 0, 1'b0);
    held = longint'(y_out);
    for (int i = 0; i < 10; i++) begin
      @(posedge clk);
      #1;
      chk("bp_y_out", longint'(y_out), held);
      chk("bp_out_valid", out_valid, 1);
      chk("bp_in_ready", in_ready, 0);
      chk("bp_busy", busy, 1);
    end
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    chk("rel_busy", busy, 0);
    chk("rel_out_valid", out_valid, 0);
    chk("rel_in_ready", in_ready, 1);
    chk("rel_y_hold", longint'(y_out), held);

    for (int k = 0; k < TAPS; k++) wcoef(k, 1);
    hclr();
    for (int i = 1; i <= 250; i++)
      send(DW'(1), 1'b1, (i < TAPS) ? i : TAPS, 1'b0);
    chk("wrap_final", longint'(y_out), TAPS);
    hclr();
    send(DW'(1), 1'b1, 1, 1'b0);

    for (int k = 0; k < TAPS; k++) wcoef(k, -65536);
    hclr();
    for (int i = 1; i <= TAPS; i++)
      send(-DW'(65536), 1'b1, longint'(i) << 32, 1'b0);
    chk("full_scale", longint'(y_out), 64'sd528280977408);

    idle_wait();
    @(negedge clk);
    in_valid = 1'b1;
    in_data  = DW'(4);
    @(posedge clk);
    #1 in_valid = 1'b0;
    repeat (60) @(posedge clk);
    #3 reset = 1'b1;
    #1;
    chk("amid_out_valid", out_valid, 0);
    chk("amid_y_out", longint'(y_out), 0);
    chk("amid_busy", busy, 0);
    chk("amid_coef_err", coef_err, 0);
    @(negedge clk);
    reset = 1'b0;
    for (int i = 0; i < TAPS; i++) begin
      hm[i] = 0;
      xm[i] = 0;
    end
    wp = 0;
    sb.delete();
    seen = 0;
    repeat (150) begin
      @(negedge clk);
      if (out_valid) seen++;
    end
    chk("no_out_after_abort", seen, 0);

    coef_we   = 1'b1;
    coef_addr = AW'(0);
    coef_data = DW'(3);
    hist_clr  = 1'b1;
    @(posedge clk);
    #1 coef_we = 1'b0;
    hist_clr = 1'b0;
    hm[0] = 3;
    send(DW'(2), 1'b1, 6, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
